regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side initiator for the 4-entry, 32-bit register file.
- Buffers register write-back requests from the datapath in a small in-order FIFO.
- Drains the FIFO onto the register file write port (WriteReg/WriteData/RegWrite), one write per cycle.
- Forwards the newest pending value for either read address, so read ports never see stale data while writes are queued.

Parameters:
- DEPTH, 4, number of queued write requests (power of two, >=2)
- DATA_W, 32, register data width
- ADDR_W, 2, register address width (2^ADDR_W registers)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  write request present
- in_ready  output  1  queue can accept a request this cycle
- in_reg  input  ADDR_W  destination register of request
- in_data  input  DATA_W  data of request
- wr_stall  input  1  hold off draining (register file busy)
- wr_en  output  1  drives RegWrite
- wr_reg  output  ADDR_W  drives WriteReg
- wr_data  output  DATA_W  drives WriteData
- fwd_reg1  input  ADDR_W  read address 1 (same as ReadReg1)
- fwd_hit1  output  1  a pending write targets fwd_reg1
- fwd_data1  output  DATA_W  newest pending data for fwd_reg1
- fwd_reg2  input  ADDR_W  read address 2 (same as ReadReg2)
- fwd_hit2  output  1  a pending write targets fwd_reg2
- fwd_data2  output  DATA_W  newest pending data for fwd_reg2
- count  output  clog2(DEPTH)+1  number of entries queued (excludes output stage)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous and active-low.
- Reset (`reset`=0, asynchronous):
  - count=0; head/tail pointers 0; all entries invalid.
  - wr_en=0, wr_reg=0, wr_data=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards all queued and in-flight writes; no partial write is issued.
- in_ready = (count < DEPTH). It is combinational from the count register only and never depends on in_valid.
- Push: on a rising edge with in_valid && in_ready, {in_reg, in_data} is written at the tail and the tail increments modulo DEPTH.
- Pop: on a rising edge with count>0 && !wr_stall:
  - The head entry loads the output stage: wr_en<=1, wr_reg<=head.reg, wr_data<=head.data.
  - The head increments modulo DEPTH.
  - Otherwise wr_en<=0, and wr_reg/wr_data hold their previous values.
- Outputs are registered, with no combinational path from inputs to wr_*. wr_en is high for exactly one cycle per popped entry.
- Latency: a request pushed at edge N is popped earliest at edge N+1, so wr_en is high during cycle N+1..N+2 (empty queue, no stall).
- Simultaneous push and pop: count is unchanged. When full, in_ready=0, so no push occurs even if a pop happens that edge.
- Ordering: strictly in order. There is no coalescing; two requests to the same register produce two writes, and the final register value is the later one.
- wr_stall only blocks the next pop. It does not cancel a write already in the output stage.
- Forwarding (combinational):
  - The search covers all valid FIFO entries plus the output stage when wr_en=1.
  - The youngest match wins: tail-1 first, down to the head, then the output stage.
  - fwd_hitN=0 with fwd_dataN=0 when there is no match.
- Pointer wrap: pointers wrap DEPTH-1 -> 0. Full vs empty is distinguished by count, not by pointer equality.

Test Plan:
- Reset, then push {reg=2, data=0xDEADBEEF} with wr_stall=0 -> wr_en=1, wr_reg=2, wr_data=0xDEADBEEF exactly one cycle later, for one cycle; count returns to 0.
- wr_stall=1, push 4 requests (regs 0,1,2,3, data 0x11..0x44) -> count=4, in_ready=0; a 5th in_valid is not accepted. Release stall -> four consecutive wr_en pulses in order 0,1,2,3.
- Push reg1=0xA then reg1=0xB while stalled, fwd_reg1=1 -> fwd_hit1=1, fwd_data1=0xB. After both drain -> fwd_hit1=0.
- Continuous push each cycle with no stall for 10 requests -> one write per cycle, count never exceeds 1, pointers wrap correctly, data order preserved.
- Fill to count=3, assert reset low mid-cycle -> wr_en=0 and count=0 immediately (asynchronous). After release, no stale writes appear.
- Full queue with simultaneous stall release and in_valid=1 -> the pop occurs, the push is rejected (in_ready was 0), and count=3 after the edge.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back queue for the register file: buffers write requests in order,
// drains one per cycle onto the write port and forwards pending data to reads.
module regfile_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_reg,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       wr_stall,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_reg,
   output logic [DATA_W-1:0]          wr_data,
   input  logic [ADDR_W-1:0]          fwd_reg1,
   output logic                       fwd_hit1,
   output logic [DATA_W-1:0]          fwd_data1,
   input  logic [ADDR_W-1:0]          fwd_reg2,
   output logic                       fwd_hit2,
   output logic [DATA_W-1:0]          fwd_data2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] reg_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              push, pop;

   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count_q != '0) && !wr_stall;

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d    = head_q + 1'b1;
         wr_reg_d  = reg_q[head_q];
         wr_data_d = data_q[head_q];
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         wr_en_q   <= pop;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         if (push) begin
            reg_q[tail_q]  <= in_reg;
            data_q[tail_q] <= in_data;
         end
      end
   end

   // Scan oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      logic [PW-1:0] idx;
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      idx       = '0;
      if (wr_en_q && (wr_reg_q == fwd_reg1)) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = wr_data_q;
      end
      if (wr_en_q && (wr_reg_q == fwd_reg2)) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (reg_q[idx] == fwd_reg1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_q[idx];
            end
            if (reg_q[idx] == fwd_reg2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_q[idx];
            end
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_reg  = wr_reg_q;
   assign wr_data = wr_data_q;
   assign count   = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: ordering, stall, full, forwarding,
// continuous streaming and asynchronous reset.
module tb_regfile_wb_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_reg;
   logic [31:0] in_data;
   logic        wr_stall;
   logic        wr_en;
   logic [1:0]  wr_reg;
   logic [31:0] wr_data;
   logic [1:0]  fwd_reg1;
   logic        fwd_hit1;
   logic [31:0] fwd_data1;
   logic [1:0]  fwd_reg2;
   logic        fwd_hit2;
   logic [31:0] fwd_data2;
   logic [2:0]  count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_reg    (in_reg),
      .in_data   (in_data),
      .wr_stall  (wr_stall),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .fwd_reg1  (fwd_reg1),
      .fwd_hit1  (fwd_hit1),
      .fwd_data1 (fwd_data1),
      .fwd_reg2  (fwd_reg2),
      .fwd_hit2  (fwd_hit2),
      .fwd_data2 (fwd_data2),
      .count     (count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [1:0] r, input logic [31:0] d);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_reg   = '0;
      in_data  = '0;
      wr_stall = 1'b0;
      fwd_reg1 = '0;
      fwd_reg2 = '0;
      step();
      step();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_reg", 32'(wr_reg), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // single write, one-cycle latency
      fwd_reg1 = 2'd2;
      push_req(2'd2, 32'hDEADBEEF);
      chk("s1_cnt1", 32'(count), 32'd1);
      chk("s1_en0", 32'(wr_en), 32'd0);
      chk("s1_fwd_q", fwd_data1, 32'hDEADBEEF);
      step();
      chk("s1_en", 32'(wr_en), 32'd1);
      chk("s1_reg", 32'(wr_reg), 32'd2);
      chk("s1_data", wr_data, 32'hDEADBEEF);
      chk("s1_cnt0", 32'(count), 32'd0);
      chk("s1_fwd_out", 32'(fwd_hit1), 32'd1);
      step();
      chk("s1_en_off", 32'(wr_en), 32'd0);
      chk("s1_fwd_gone", 32'(fwd_hit1), 32'd0);

      // fill under stall, reject 5th, then pop with simultaneous push
      wr_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_req(2'(i), 32'h11 * (i + 1));
      end
      chk("s2_cnt4", 32'(count), 32'd4);
      chk("s2_rdy0", 32'(in_ready), 32'd0);
      chk("s2_en0", 32'(wr_en), 32'd0);
      fwd_reg1 = 2'd3;
      fwd_reg2 = 2'd0;
      #1;
      chk("s2_fwd1", fwd_data1, 32'h44);
      chk("s2_fwd2", fwd_data2, 32'h11);
      push_req(2'd0, 32'h55);
      chk("s2_cnt_rej", 32'(count), 32'd4);
      wr_stall = 1'b0;
      push_req(2'd0, 32'h55);
      chk("s6_cnt3", 32'(count), 32'd3);
      chk("s6_en", 32'(wr_en), 32'd1);
      chk("s2_reg0", 32'(wr_reg), 32'd0);
      chk("s2_dat0", wr_data, 32'h11);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("s2_en_i", 32'(wr_en), 32'd1);
         chk("s2_reg_i", 32'(wr_reg), 32'(i));
         chk("s2_dat_i", wr_data, 32'h11 * (i + 1));
      end
      chk("s2_cnt_end", 32'(count), 32'd0);
      step();
      chk("s2_en_end", 32'(wr_en), 32'd0);

      // forwarding picks the youngest pending write
      wr_stall = 1'b1;
      fwd_reg1 = 2'd1;
      fwd_reg2 = 2'd2;
      push_req(2'd1, 32'hA);
      push_req(2'd1, 32'hB);
      chk("s3_hit1", 32'(fwd_hit1), 32'd1);
      chk("s3_dat1", fwd_data1, 32'hB);
      chk("s3_hit2", 32'(fwd_hit2), 32'd0);
      chk("s3_dat2", fwd_data2, 32'd0);
      wr_stall = 1'b0;
      step();
      chk("s3_wrA", wr_data, 32'hA);
      chk("s3_fwdB_a", fwd_data1, 32'hB);
      step();
      chk("s3_wrB", wr_data, 32'hB);
      chk("s3_fwdB_b", fwd_data1, 32'hB);
      step();
      chk("s3_hit_off", 32'(fwd_hit1), 32'd0);

      // continuous streaming across pointer wrap
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_reg   = 2'(k);
         in_data  = 32'h100 + k;
         step();
         chk("s4_cnt", 32'(count), 32'd1);
         if (k > 0) begin
            chk("s4_en", 32'(wr_en), 32'd1);
            chk("s4_reg", 32'(wr_reg), 32'((k - 1) % 4));
            chk("s4_dat", wr_data, 32'h100 + k - 1);
         end
      end
      in_valid = 1'b0;
      step();
      chk("s4_last", wr_data, 32'h109);
      chk("s4_cnt0", 32'(count), 32'd0);
      step();

      // asynchronous reset mid-operation
      wr_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_req(2'(i), 32'hC0 + i);
      end
      chk("s5_cnt3", 32'(count), 32'd3);
      wr_stall = 1'b0;
      step();
      chk("s5_en_pre", 32'(wr_en), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("s5_en_rst", 32'(wr_en), 32'd0);
      chk("s5_cnt_rst", 32'(count), 32'd0);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s5_no_stale", 32'(wr_en), 32'd0);
         chk("s5_cnt_post", 32'(count), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
